// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU has default priority, the loader is force-granted
// after STARVE_LIMIT blocked cycles, and 1-cycle read data is routed to its owner.
module dm_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_rvalid,
   output logic [DW-1:0] ldr_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   logic [3:0] r_starve_cnt;
   logic       r_rd_pend;
   owner_t     r_rd_owner;

   logic       w_ldr_gnt;
   logic       w_cpu_gnt;
   logic       w_rd_issue;

   // Grants are masked during reset so no memory access can slip through.
   assign w_ldr_gnt  = ~reset & ldr_req & (~cpu_req | (r_starve_cnt >= LIMIT));
   assign w_cpu_gnt  = ~reset & cpu_req & ~w_ldr_gnt;
   assign w_rd_issue = (w_cpu_gnt & ~cpu_we) | (w_ldr_gnt & ~ldr_we);

   assign cpu_gnt = w_cpu_gnt;
   assign ldr_gnt = w_ldr_gnt;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_ldr_gnt) begin
         mem_we    = ldr_we;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
      end else if (w_cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= '0;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= OWN_CPU;
      end else begin
         if (ldr_req && !w_ldr_gnt)
            r_starve_cnt <= (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 4'd1;
         else
            r_starve_cnt <= '0;
         r_rd_pend  <= w_rd_issue;
         r_rd_owner <= w_ldr_gnt ? OWN_LDR : OWN_CPU;
      end
   end

   // Memory data arrives a cycle after the address, so routing is combinational
   // from the registered owner; reset suppresses a return already in flight.
   always_comb begin
      cpu_rvalid = ~reset & r_rd_pend & (r_rd_owner == OWN_CPU);
      ldr_rvalid = ~reset & r_rd_pend & (r_rd_owner == OWN_LDR);
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 1-cycle-latency memory model.
module tb_dm_arbiter;

   logic       clk;
   logic       reset;
   logic       cpu_req, cpu_we;
   logic [7:0] cpu_addr, cpu_wdata;
   logic       cpu_gnt, cpu_rvalid;
   logic [7:0] cpu_rdata;
   logic       ldr_req, ldr_we;
   logic [7:0] ldr_addr, ldr_wdata;
   logic       ldr_gnt, ldr_rvalid;
   logic [7:0] ldr_rdata;
   logic       mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0] mem [0:255];
   int checks = 0;
   int errors = 0;

   dm_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(3)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic set_idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1;
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h09; cpu_wdata = 8'h12;
      ldr_req = 1; ldr_we = 1; ldr_addr = 8'h0A; ldr_wdata = 8'h34;
      @(negedge clk); #1;
      checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %b exp 0", cpu_gnt); end
      checks++; if (ldr_gnt !== 1'b0) begin errors++; $display("FAIL reset_ldr_gnt got %b exp 0", ldr_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
      checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {cpu_rvalid, ldr_rvalid}); end
      checks++; if ({cpu_rdata, ldr_rdata} !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", {cpu_rdata, ldr_rdata}); end
      checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve got %0d exp 0", dut.r_starve_cnt); end
      @(negedge clk);
      reset = 0;
      set_idle();
      #1;
      checks++; if ({mem_we, mem_addr, mem_wdata} !== 17'h0) begin errors++; $display("FAIL idle_mem got %h exp 0", {mem_we, mem_addr, mem_wdata}); end
   endtask

   task automatic test_cpu_write();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h03; cpu_wdata = 8'hF0;
      #1;
      checks++; if ({cpu_gnt, ldr_gnt} !== 2'b10) begin errors++; $display("FAIL cpu_wr_gnt got %b exp 10", {cpu_gnt, ldr_gnt}); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h03, 8'hF0}) begin
         errors++; $display("FAIL cpu_wr_mem got we=%b addr=%h wd=%h exp 1/03/F0", mem_we, mem_addr, mem_wdata); end
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_wr_no_rvalid got %b exp 0", cpu_rvalid); end
      checks++; if (mem[3] !== 8'hF0) begin errors++; $display("FAIL cpu_wr_memval got %h exp F0", mem[3]); end
   endtask

   task automatic test_cpu_read();
      @(negedge clk);
      mem[6] = 8'hAA;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h06;
      #1;
      checks++; if ({cpu_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h06}) begin
         errors++; $display("FAIL cpu_rd_issue got gnt=%b we=%b addr=%h exp 1/0/06", cpu_gnt, mem_we, mem_addr); end
      @(negedge clk);
      set_idle();
      #1;
      checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hAA}) begin
         errors++; $display("FAIL cpu_rd_return got v=%b d=%h exp 1/AA", cpu_rvalid, cpu_rdata); end
      checks++; if ({ldr_rvalid, ldr_rdata} !== 9'h0) begin
         errors++; $display("FAIL cpu_rd_ldr_quiet got v=%b d=%h exp 0/00", ldr_rvalid, ldr_rdata); end
      @(negedge clk); #1;
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_single got %b exp 0", cpu_rvalid); end
   endtask

   task automatic test_contention();
      logic [3:0] exp_cnt [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      logic       exp_l   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'h11;
      ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h22;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if ({cpu_gnt, ldr_gnt} !== {~exp_l[i], exp_l[i]}) begin
            errors++; $display("FAIL contend_gnt[%0d] got c=%b l=%b exp c=%b l=%b", i, cpu_gnt, ldr_gnt, ~exp_l[i], exp_l[i]); end
         checks++; if (mem_addr !== (exp_l[i] ? 8'h20 : 8'h10)) begin
            errors++; $display("FAIL contend_addr[%0d] got %h exp %h", i, mem_addr, exp_l[i] ? 8'h20 : 8'h10); end
         @(posedge clk); #1;
         checks++; if (dut.r_starve_cnt !== exp_cnt[i]) begin
            errors++; $display("FAIL contend_starve[%0d] got %0d exp %0d", i, dut.r_starve_cnt, exp_cnt[i]); end
         @(negedge clk);
      end
      set_idle();
   endtask

   task automatic test_alt_reads();
      @(negedge clk);
      mem[0] = 8'hF0; mem[7] = 8'h55;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
      ldr_req = 1; ldr_we = 0; ldr_addr = 8'h07;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({cpu_gnt, ldr_gnt} !== 2'b10) begin errors++; $display("FAIL alt_pre_gnt[%0d] got %b exp 10", i, {cpu_gnt, ldr_gnt}); end
         if (i > 0) begin
            checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hF0}) begin
               errors++; $display("FAIL alt_b2b_cpu[%0d] got v=%b d=%h exp 1/F0", i, cpu_rvalid, cpu_rdata); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if ({ldr_gnt, cpu_gnt, mem_addr} !== {2'b10, 8'h07}) begin
         errors++; $display("FAIL alt_force got l=%b c=%b addr=%h exp 1/0/07", ldr_gnt, cpu_gnt, mem_addr); end
      checks++; if ({cpu_rvalid, cpu_rdata, ldr_rvalid} !== {1'b1, 8'hF0, 1'b0}) begin
         errors++; $display("FAIL alt_cpu_ret got cv=%b cd=%h lv=%b exp 1/F0/0", cpu_rvalid, cpu_rdata, ldr_rvalid); end
      @(negedge clk);
      ldr_req = 0;
      #1;
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL alt_cpu_regrant got %b exp 1", cpu_gnt); end
      checks++; if ({ldr_rvalid, ldr_rdata} !== {1'b1, 8'h55}) begin
         errors++; $display("FAIL alt_ldr_ret got v=%b d=%h exp 1/55", ldr_rvalid, ldr_rdata); end
      checks++; if ({cpu_rvalid, cpu_rdata} !== 9'h0) begin
         errors++; $display("FAIL alt_no_cross got v=%b d=%h exp 0/00", cpu_rvalid, cpu_rdata); end
      @(negedge clk);
      set_idle();
      #1;
      checks++; if ({cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata} !== {1'b1, 8'hF0, 1'b0, 8'h00}) begin
         errors++; $display("FAIL alt_tail got cv=%b cd=%h lv=%b ld=%h exp 1/F0/0/00", cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata); end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h06;
      ldr_req = 1; ldr_we = 0; ldr_addr = 8'h01;
      #1;
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rmr_gnt got %b exp 1", cpu_gnt); end
      @(negedge clk);
      reset = 1;
      #1;
      checks++; if ({cpu_rvalid, cpu_rdata} !== 9'h0) begin
         errors++; $display("FAIL rmr_n1 got v=%b d=%h exp 0/00", cpu_rvalid, cpu_rdata); end
      checks++; if ({cpu_gnt, ldr_gnt, mem_we} !== 3'b000) begin
         errors++; $display("FAIL rmr_gnt_masked got %b exp 000", {cpu_gnt, ldr_gnt, mem_we}); end
      @(posedge clk); #1;
      checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("FAIL rmr_starve got %0d exp 0", dut.r_starve_cnt); end
      @(negedge clk);
      reset = 0;
      set_idle();
      #1;
      checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin
         errors++; $display("FAIL rmr_n2 got %b exp 00", {cpu_rvalid, ldr_rvalid}); end
   endtask

   task automatic test_drop_req();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 8'h11;
      ldr_req = 1; ldr_we = 1; ldr_addr = 8'h05; ldr_wdata = 8'h22;
      #1;
      checks++; if ({cpu_gnt, ldr_gnt, mem_wdata} !== {2'b10, 8'h11}) begin
         errors++; $display("FAIL same_addr got c=%b l=%b wd=%h exp 1/0/11", cpu_gnt, ldr_gnt, mem_wdata); end
      @(negedge clk);
      #1;
      checks++; if (mem[5] !== 8'h11) begin errors++; $display("FAIL same_addr_mem got %h exp 11", mem[5]); end
      @(posedge clk); #1;
      checks++; if (dut.r_starve_cnt !== 4'd2) begin errors++; $display("FAIL drop_pre got %0d exp 2", dut.r_starve_cnt); end
      @(negedge clk);
      ldr_req = 0;
      @(posedge clk); #1;
      checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("FAIL drop_clear got %0d exp 0", dut.r_starve_cnt); end
      @(negedge clk);
      ldr_req = 1;
      #1;
      checks++; if (ldr_gnt !== 1'b0) begin errors++; $display("FAIL drop_restart got %b exp 0", ldr_gnt); end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_loader_only();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ldr_req = 1; ldr_we = 1; ldr_addr = 8'(i); ldr_wdata = 8'hA0 + 8'(i);
         #1;
         checks++; if ({ldr_gnt, cpu_gnt, mem_we, mem_addr} !== {3'b101, 8'(i)}) begin
            errors++; $display("FAIL ldr_wr[%0d] got l=%b c=%b we=%b addr=%h", i, ldr_gnt, cpu_gnt, mem_we, mem_addr); end
         @(posedge clk); #1;
         checks++; if (dut.r_starve_cnt !== 4'd0) begin errors++; $display("FAIL ldr_starve[%0d] got %0d exp 0", i, dut.r_starve_cnt); end
      end
      @(negedge clk);
      set_idle();
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem[i] !== 8'hA0 + 8'(i)) begin
            errors++; $display("FAIL ldr_mem[%0d] got %h exp %h", i, mem[i], 8'hA0 + 8'(i)); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem_rdata = 8'h00;
      reset = 1;
      set_idle();
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_contention();
      test_alt_reads();
      test_reset_mid_read();
      test_drop_req();
      test_loader_only();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout after 20000 time units");
      $fatal(1, "timeout");
   end

endmodule
